// File: rtl/pwm_decoder.sv
// PWM reader: measures period and high time (in clk cycles) between rising samples,
// strobes valid per period and timeout on a stuck input. Define PWM_DECODER_SYNC_EN to add a 2-flop input synchronizer.
module pwm_decoder #(
   parameter int WIDTH      = 8,
   parameter int MAX_PERIOD = (1 << WIDTH) - 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             valid,
   output logic             timeout,
   output logic             stuck_level
);

   localparam logic [WIDTH-1:0] MAXP = WIDTH'(MAX_PERIOD);

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t           state, state_d;
   logic             s, s_q, rise, at_limit;
   logic [WIDTH-1:0] per_cnt, per_d, hi_cnt, hi_d, period_d, high_d;
   logic             valid_d, timeout_d, stuck_d;

`ifdef PWM_DECODER_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[0], pwm_in};
   end

   assign s = sync_q[1];
`else
   assign s = pwm_in;
`endif

   assign rise     = s & ~s_q;
   assign at_limit = (per_cnt == MAXP);

   always_comb begin
      state_d   = state;
      per_d     = per_cnt;
      hi_d      = hi_cnt;
      period_d  = period;
      high_d    = high_time;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      stuck_d   = stuck_level;
      if (!enable) begin
         state_d = IDLE;
         per_d   = '0;
         hi_d    = '0;
      end else if (rise) begin
         // A rise always wins over a coincident timeout
         state_d = MEASURE;
         per_d   = WIDTH'(1);
         hi_d    = WIDTH'(1);
         if (state == MEASURE) begin
            period_d = per_cnt;
            high_d   = hi_cnt;
            valid_d  = 1'b1;
         end
      end else if (at_limit) begin
         state_d   = IDLE;
         per_d     = '0;
         hi_d      = '0;
         timeout_d = 1'b1;
         stuck_d   = s;
      end else begin
         per_d = per_cnt + 1'b1;
         case (state)
            IDLE:    hi_d = hi_cnt;
            MEASURE: if (s) hi_d = hi_cnt + 1'b1;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         per_cnt     <= '0;
         hi_cnt      <= '0;
         period      <= '0;
         high_time   <= '0;
         valid       <= 1'b0;
         timeout     <= 1'b0;
         stuck_level <= 1'b0;
         s_q         <= 1'b0;
      end else begin
         state       <= state_d;
         per_cnt     <= per_d;
         hi_cnt      <= hi_d;
         period      <= period_d;
         high_time   <= high_d;
         valid       <= valid_d;
         timeout     <= timeout_d;
         stuck_level <= stuck_d;
         s_q         <= s;
      end
   end

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: table of PWM waveforms plus reset/enable/stuck-input sequences,
// scored cycle by cycle against expectations derived from the driven stimulus.
module tb_pwm_decoder;

`ifdef PWM_DECODER_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   localparam int MAXP = 255;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic       pwm_in = 1'b0;
   logic [7:0] period, high_time;
   logic       valid, timeout, stuck_level;

   pwm_decoder #(.WIDTH(8), .MAX_PERIOD(MAXP)) dut (
      .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
      .period(period), .high_time(high_time), .valid(valid),
      .timeout(timeout), .stuck_level(stuck_level)
   );

   always #5 clk = ~clk;

   typedef struct { int p; int h; int n; int ep; int eh; } vec_t;
   typedef struct { int due; int p; int h; } rep_t;
   typedef struct { int due; logic lvl; } to_t;

   vec_t tbl[6];
   rep_t vq[$];
   to_t  tq[$];

   int   errors = 0, checks = 0;
   int   cyc = 0, since = 0, hsince = 0, last_rise = 0;
   int   ep = 0, eh = 0, n_exp = 0, n_seen = 0;
   logic es = 1'b0, armed = 1'b0, pwm_prev = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // One clock edge with the currently driven inputs, then score all outputs.
   task automatic tick();
      rep_t r;
      int   ev, et;
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
         vq.delete();
         tq.delete();
         armed = 1'b0;
         ep = 0; eh = 0; es = 1'b0;
      end else if (!enable) begin
         armed = 1'b0;
      end else begin
         if (pwm_in && !pwm_prev) begin
            if (armed) begin
               r.due = cyc + LAT; r.p = since; r.h = hsince;
               vq.push_back(r);
               n_exp++;
            end
            armed = 1'b1; since = 0; hsince = 0; last_rise = cyc;
         end
         since++;
         if (pwm_in) hsince++;
      end
      pwm_prev = reset ? 1'b0 : pwm_in;
      ev = 0; et = 0;
      if (vq.size() > 0 && vq[0].due == cyc) begin
         ev = 1; ep = vq[0].p; eh = vq[0].h;
         void'(vq.pop_front());
      end
      if (tq.size() > 0 && tq[0].due == cyc) begin
         et = 1; es = tq[0].lvl; armed = 1'b0;
         void'(tq.pop_front());
      end
      chk("valid", int'(valid), ev);
      chk("timeout", int'(timeout), et);
      chk("period", int'(period), ep);
      chk("high_time", int'(high_time), eh);
      chk("stuck_level", int'(stuck_level), int'(es));
      if (valid) n_seen++;
   endtask

   task automatic drv(input logic p, input logic en, input logic rst);
      pwm_in = p; enable = en; reset = rst;
      tick();
   endtask

   task automatic run_wave(input int p, input int h, input int n);
      for (int k = 0; k < n; k++)
         for (int i = 0; i < p; i++) drv(i < h, 1'b1, 1'b0);
   endtask

   // Hold the input at one level; timeouts are due MAXP cycles after the last rise, then every MAXP+1.
   task automatic hold(input logic lvl, input int n);
      to_t t;
      int  start;
      start = cyc + 1;
      drv(lvl, 1'b1, 1'b0);
      t.lvl = lvl;
      t.due = last_rise + LAT + MAXP;
      while (t.due < start + n) begin
         tq.push_back(t);
         t.due += MAXP + 1;
      end
      for (int i = 1; i < n; i++) drv(lvl, 1'b1, 1'b0);
   endtask

   initial begin
      int base, t0;
      tbl[0] = '{p: 10, h: 3,  n: 5, ep: 10, eh: 3};
      tbl[1] = '{p: 20, h: 15, n: 3, ep: 20, eh: 15};
      tbl[2] = '{p: 10, h: 1,  n: 3, ep: 10, eh: 1};
      tbl[3] = '{p: 10, h: 9,  n: 3, ep: 10, eh: 9};
      tbl[4] = '{p: 2,  h: 1,  n: 6, ep: 2,  eh: 1};
      tbl[5] = '{p: 10, h: 3,  n: 3, ep: 10, eh: 3};

      for (int i = 0; i < 3; i++) drv(1'b0, 1'b1, 1'b1);
      drv(1'b0, 1'b1, 1'b0);

      // Steady waveforms, a mid-stream change, and boundary duties
      for (int e = 0; e < 6; e++) begin
         run_wave(tbl[e].p, tbl[e].h, tbl[e].n);
         chk("tbl_period", int'(period), tbl[e].ep);
         chk("tbl_high", int'(high_time), tbl[e].eh);
      end
      t0 = cyc;
      chk("timeout_free", int'(timeout), 0);

      // Reset four cycles into a period: outputs clear, two more rises before a report
      for (int i = 0; i < 4; i++) drv(i < 3, 1'b1, 1'b0);
      drv(1'b0, 1'b1, 1'b1);
      chk("rst_period", int'(period), 0);
      chk("rst_high", int'(high_time), 0);
      for (int i = 5; i < 10; i++) drv(1'b0, 1'b1, 1'b0);
      base = n_seen;
      run_wave(10, 3, 3);
      chk("rst_rearm_valids", n_seen - base, 2);

      // Enable low for five cycles: outputs hold, same re-arm
      for (int i = 0; i < 4; i++) drv(i < 3, 1'b1, 1'b0);
      for (int i = 4; i < 9; i++) drv(1'b0, 1'b0, 1'b0);
      chk("en_hold_period", int'(period), 10);
      chk("en_hold_high", int'(high_time), 3);
      drv(1'b0, 1'b1, 1'b0);
      base = n_seen;
      run_wave(10, 3, 3);
      chk("en_rearm_valids", n_seen - base, 2);

      // Stuck low then stuck high
      run_wave(20, 15, 2);
      hold(1'b0, 600);
      chk("stuck_lo_period", int'(period), 20);
      chk("stuck_lo_level", int'(stuck_level), 0);
      hold(1'b1, 600);
      chk("stuck_hi_high", int'(high_time), 15);
      chk("stuck_hi_level", int'(stuck_level), 1);
      base = n_seen;
      run_wave(10, 3, 3);
      chk("post_stuck_valids", n_seen - base, 1);
      for (int i = 0; i < 4; i++) drv(1'b0, 1'b1, 1'b0);

      chk("valid_count", n_seen, n_exp);
      chk("pending_events", vq.size() + tq.size(), 0);
      chk("cycles_advanced", int'(cyc > t0), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
